// File: rtl/vpu_ctrl_pkg.sv
// Shared types and size helpers for the vector pipeline stall controller.
package vpu_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        VEXEC = 1'b1
    } stall_state_t;

    typedef struct packed {
        logic fd;
        logic de;
        logic em;
        logic mw;
    } stage_en_t;

    function automatic int unsigned calc_nchunk(input int unsigned lanes,
                                                input int unsigned chunk);
        return lanes / chunk;
    endfunction

    // Chunk index needs at least one bit even when an op fits in a single EX cycle.
    function automatic int unsigned calc_cnt_w(input int unsigned nchunk);
        int unsigned w;
        w = $clog2(nchunk);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vec_chunk_cnt.sv
// Chunk index counter for vector ops: clear beats load beats increment; hold otherwise.
module vec_chunk_cnt
    import vpu_ctrl_pkg::*;
#(
    parameter int unsigned NCHUNK = 4,
    parameter int unsigned CNT_W  = calc_cnt_w(NCHUNK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(NCHUNK - 1);

    logic [CNT_W-1:0] r_cnt;

    // Load sets 1 because chunk 0 is consumed in the start cycle itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= CntOne;
        end else if (inc_i) begin
            r_cnt <= r_cnt + CntOne;
        end
    end

    assign cnt_o  = r_cnt;
    assign last_o = (r_cnt == CntLast);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline enable/flush sequencer: resolves memory, vector, branch and load-use hazards
// into per-bank enables and bubble requests, and counts front-end stall cycles.
module pipe_stall_ctrl
    import vpu_ctrl_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      mem_busy_i,
    input  logic                                      branch_taken_i,
    input  logic                                      load_use_i,
    input  logic                                      vec_start_i,
    output logic                                      en_fd_o,
    output logic                                      en_de_o,
    output logic                                      en_em_o,
    output logic                                      en_mw_o,
    output logic                                      flush_fd_o,
    output logic                                      flush_de_o,
    output logic                                      vec_busy_o,
    output logic [calc_cnt_w(calc_nchunk(LANES, CHUNK))-1:0] vec_chunk_o,
    output logic                                      vec_done_o,
    output logic [15:0]                               stall_cnt_o
);

    localparam int unsigned NCHUNK = calc_nchunk(LANES, CHUNK);
    localparam int unsigned CNT_W  = calc_cnt_w(NCHUNK);

    stall_state_t     r_state;
    stall_state_t     w_state_d;
    logic [15:0]      r_stall_cnt;

    stage_en_t        w_en;
    logic             w_flush_fd;
    logic             w_flush_de;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_chunk;

    logic             w_cnt_load;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_last;

    vec_chunk_cnt #(
        .NCHUNK (NCHUNK),
        .CNT_W  (CNT_W)
    ) u_vec_chunk_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (w_cnt_load),
        .inc_i  (w_cnt_inc),
        .clr_i  (w_cnt_clr),
        .cnt_o  (w_cnt),
        .last_o (w_cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Priority: mem_busy > vector sequencing > branch > load_use.
    always_comb begin
        w_en       = '{fd: 1'b1, de: 1'b1, em: 1'b1, mw: 1'b1};
        w_flush_fd = 1'b0;
        w_flush_de = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_chunk    = '0;
        w_state_d  = r_state;
        w_cnt_load = 1'b0;
        w_cnt_inc  = 1'b0;
        w_cnt_clr  = 1'b0;

        if (!reset) begin
            w_en = '0;
        end else if (mem_busy_i) begin
            w_en = '0;
            if (r_state == VEXEC) begin
                w_busy  = 1'b1;
                w_chunk = w_cnt;
            end
        end else if (r_state == VEXEC) begin
            w_busy  = 1'b1;
            w_chunk = w_cnt;
            if (w_cnt_last) begin
                w_done    = 1'b1;
                w_state_d = RUN;
                w_cnt_clr = 1'b1;
            end else begin
                w_en.fd   = 1'b0;
                w_en.de   = 1'b0;
                w_cnt_inc = 1'b1;
            end
        end else if (vec_start_i) begin
            w_busy = 1'b1;
            if (NCHUNK == 1) begin
                w_done = 1'b1;
            end else begin
                w_en.fd    = 1'b0;
                w_en.de    = 1'b0;
                w_state_d  = VEXEC;
                w_cnt_load = 1'b1;
            end
        end else if (branch_taken_i) begin
            w_flush_fd = 1'b1;
            w_flush_de = 1'b1;
        end else if (load_use_i) begin
            w_en.fd    = 1'b0;
            w_flush_de = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (!w_en.fd && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign en_fd_o     = w_en.fd;
    assign en_de_o     = w_en.de;
    assign en_em_o     = w_en.em;
    assign en_mw_o     = w_en.mw;
    assign flush_fd_o  = w_flush_fd;
    assign flush_de_o  = w_flush_de;
    assign vec_busy_o  = w_busy;
    assign vec_chunk_o = w_chunk;
    assign vec_done_o  = w_done;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl with LANES=8, CHUNK=2 (4 chunks per op).
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_busy;
    logic        branch_taken;
    logic        load_use;
    logic        vec_start;
    logic        en_fd;
    logic        en_de;
    logic        en_em;
    logic        en_mw;
    logic        flush_fd;
    logic        flush_de;
    logic        vec_busy;
    logic [1:0]  vec_chunk;
    logic        vec_done;
    logic [15:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observed control bundle: {en_fd,en_de,en_em,en_mw,flush_fd,flush_de,vec_busy,vec_done}
    logic [7:0] obs;
    assign obs = {en_fd, en_de, en_em, en_mw, flush_fd, flush_de, vec_busy, vec_done};

    pipe_stall_ctrl #(
        .LANES (8),
        .CHUNK (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_busy_i     (mem_busy),
        .branch_taken_i (branch_taken),
        .load_use_i     (load_use),
        .vec_start_i    (vec_start),
        .en_fd_o        (en_fd),
        .en_de_o        (en_de),
        .en_em_o        (en_em),
        .en_mw_o        (en_mw),
        .flush_fd_o     (flush_fd),
        .flush_de_o     (flush_de),
        .vec_busy_o     (vec_busy),
        .vec_chunk_o    (vec_chunk),
        .vec_done_o     (vec_done),
        .stall_cnt_o    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_busy     = 1'b0;
        branch_taken = 1'b0;
        load_use     = 1'b0;
        vec_start    = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        mem_busy     = 1'b1;
        branch_taken = 1'b1;
        load_use     = 1'b1;
        vec_start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_cmp++;
            if (obs !== 8'b0000_0000) begin
                n_fail++;
                $display("FAIL reset_ctrl cyc%0d: got %b want 00000000", i, obs);
            end
            n_cmp++;
            if (vec_chunk !== 2'd0 || stall_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_cnt cyc%0d: chunk %0d stall %0d want 0/0",
                         i, vec_chunk, stall_cnt);
            end
            tick();
        end
        reset = 1'b1;
        idle_inputs();
        #3;
        n_cmp++;
        if (obs !== 8'b1111_0000) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 11110000", obs);
        end
        tick();
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_vector();
        logic [7:0] exp_ctrl [4];
        exp_ctrl[0] = 8'b0011_0010;
        exp_ctrl[1] = 8'b0011_0010;
        exp_ctrl[2] = 8'b0011_0010;
        exp_ctrl[3] = 8'b1111_0011;
        for (int k = 0; k < 4; k++) begin
            vec_start = (k == 0);
            #3;
            n_cmp++;
            if (obs !== exp_ctrl[k] || vec_chunk !== 2'(k)) begin
                n_fail++;
                $display("FAIL vector T+%0d: ctrl %b chunk %0d want %b chunk %0d",
                         k, obs, vec_chunk, exp_ctrl[k], k);
            end
            tick();
        end
        idle_inputs();
        #3;
        n_cmp++;
        if (obs !== 8'b1111_0000 || stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL vector_after: ctrl %b stall %0d want 11110000 stall 3", obs, stall_cnt);
        end
        tick();
    endtask

    task automatic test_vec_mem_busy();
        logic [7:0] exp_ctrl  [6];
        logic [1:0] exp_chunk [6];
        exp_ctrl[0] = 8'b0011_0010; exp_chunk[0] = 2'd0;
        exp_ctrl[1] = 8'b0000_0010; exp_chunk[1] = 2'd1;
        exp_ctrl[2] = 8'b0000_0010; exp_chunk[2] = 2'd1;
        exp_ctrl[3] = 8'b0011_0010; exp_chunk[3] = 2'd1;
        exp_ctrl[4] = 8'b0011_0010; exp_chunk[4] = 2'd2;
        exp_ctrl[5] = 8'b1111_0011; exp_chunk[5] = 2'd3;
        for (int k = 0; k < 6; k++) begin
            vec_start = (k == 0);
            mem_busy  = (k == 1 || k == 2);
            #3;
            n_cmp++;
            if (obs !== exp_ctrl[k] || vec_chunk !== exp_chunk[k]) begin
                n_fail++;
                $display("FAIL vec_mem_busy T+%0d: ctrl %b chunk %0d want %b chunk %0d",
                         k, obs, vec_chunk, exp_ctrl[k], exp_chunk[k]);
            end
            tick();
        end
        idle_inputs();
        #3;
        n_cmp++;
        if (stall_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL vec_mem_busy_stall: got %0d want 8", stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        load_use     = 1'b1;
        #3;
        n_cmp++;
        if (obs !== 8'b1111_1100) begin
            n_fail++;
            $display("FAIL branch: got %b want 11111100", obs);
        end
        tick();
        idle_inputs();
        #3;
        n_cmp++;
        if (obs !== 8'b1111_0000 || stall_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL branch_after: ctrl %b stall %0d want 11110000 stall 8", obs, stall_cnt);
        end
        tick();
    endtask

    task automatic test_load_use();
        load_use = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #3;
            n_cmp++;
            if (obs !== 8'b0111_0100) begin
                n_fail++;
                $display("FAIL load_use cyc%0d: got %b want 01110100", k, obs);
            end
            tick();
        end
        idle_inputs();
        #3;
        n_cmp++;
        if (obs !== 8'b1111_0000 || stall_cnt !== 16'd10) begin
            n_fail++;
            $display("FAIL load_use_after: ctrl %b stall %0d want 11110000 stall 10",
                     obs, stall_cnt);
        end
        tick();
    endtask

    task automatic test_start_under_mem_busy();
        mem_busy  = 1'b1;
        vec_start = 1'b1;
        #3;
        n_cmp++;
        if (obs !== 8'b0000_0000 || vec_chunk !== 2'd0) begin
            n_fail++;
            $display("FAIL start_mem_busy: ctrl %b chunk %0d want 00000000 chunk 0",
                     obs, vec_chunk);
        end
        tick();
        idle_inputs();
        #3;
        n_cmp++;
        if (obs !== 8'b1111_0000 || stall_cnt !== 16'd11) begin
            n_fail++;
            $display("FAIL start_mem_busy_after: ctrl %b stall %0d want 11110000 stall 11",
                     obs, stall_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_vec();
        vec_start = 1'b1;
        #3;
        n_cmp++;
        if (obs !== 8'b0011_0010) begin
            n_fail++;
            $display("FAIL rst_mid_start: got %b want 00110010", obs);
        end
        tick();
        vec_start = 1'b0;
        reset     = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 8'b0000_0000 || vec_chunk !== 2'd0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_forced: ctrl %b chunk %0d stall %0d want 00000000/0/0",
                     obs, vec_chunk, stall_cnt);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #3;
            n_cmp++;
            if (obs !== 8'b1111_0000 || vec_chunk !== 2'd0) begin
                n_fail++;
                $display("FAIL rst_mid_after cyc%0d: ctrl %b chunk %0d want 11110000 chunk 0",
                         k, obs, vec_chunk);
            end
            tick();
        end
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_stall: got %0d want 0", stall_cnt);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_vector();
        test_vec_mem_busy();
        test_branch();
        test_load_use();
        test_start_under_mem_busy();
        test_reset_mid_vec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
